uart_tx: RTL and testbench

//  8N1 UART transmitter; counterpart to the team's uart_rx (LSB first, idle-high line).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_tx.sv | 127 ++++++++++++
 tb/tb_uart_tx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter and receiver.
// Optional parity is selected in uart_tx with UART_TX_PARITY_EN.
package uart_pkg;

  localparam int UART_FRAME_DATA_BITS = 8;
  localparam int UART_CNT_W           = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic [UART_CNT_W-1:0] baud_divisor(input int unsigned clk_hz,
                                                         input int unsigned baud);
    return UART_CNT_W'(clk_hz / baud);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable baud down-counter: tick on terminal count, auto-reload, held at 0 while disabled.
// Shared between uart_tx and uart_rx.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter logic [UART_CNT_W-1:0] RELOAD = 16'd9
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic load,
  output logic tick
);

  logic [UART_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle-high line, registered txd/tx_busy/tx_done.
// Define UART_TX_PARITY_EN to insert an even-parity bit after d[7] (11-bit frame).
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | driving the start bit (0)
// DATA   | driving d[0..7], one per baud period
// PARITY | driving the even-parity bit (parity build only)
// STOP   | driving the stop bit (1); tx_done fires at its end
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 200000000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned BAUD_DIVISOR = 32'(baud_divisor(CLK_HZ, BAUD))
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [UART_FRAME_DATA_BITS-1:0] tx_data,
  input  logic                            tx_start,
  output logic                            tx_busy,
  output logic                            tx_done,
  output logic                            txd
);

  localparam logic [UART_CNT_W-1:0] RELOAD   = UART_CNT_W'(BAUD_DIVISOR - 1);
  localparam logic [2:0]            LAST_BIT = 3'(UART_FRAME_DATA_BITS - 1);

  tx_state_t                       state;
  logic [UART_FRAME_DATA_BITS-1:0] shift_reg;
  logic [2:0]                      bit_cnt;
  logic                            baud_tick;
  logic                            accept;
`ifdef UART_TX_PARITY_EN
  logic                            par_bit;
`endif

  assign accept = (state == IDLE) && tx_start;

  uart_baud_tick #(
    .RELOAD(RELOAD)
  ) u_baud (
    .clk (clk),
    .nrst(nrst),
    .en  (state != IDLE),
    .load(accept),
    .tick(baud_tick)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      txd       <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            shift_reg <= tx_data;
            bit_cnt   <= '0;
            txd       <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= START;
`ifdef UART_TX_PARITY_EN
            par_bit   <= ^tx_data;
`endif
          end else begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
          end
        end
        START: begin
          if (baud_tick) begin
            txd       <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              txd   <= par_bit;
              state <= PARITY;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              txd       <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            txd   <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            state   <= IDLE;
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          txd     <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLK_HZ=1000, BAUD=100 (10 clk per bit).
module tb_uart_tx;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk;
  logic       nrst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       txd;

  int checks;
  int failures;

  uart_tx #(
    .CLK_HZ(1000),
    .BAUD  (100)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .txd     (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // line: bit i is the level during bit time i (start, d0..d7, stop); par: even parity
  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
    logic       par;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame_of(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return {1'b1, v.par, v.line[8:0]};
`else
    return {1'b0, v.line};
`endif
  endfunction

  // Raise tx_start at a negedge; returns at the negedge after the acceptance edge.
  task automatic launch(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Starts at the negedge after acceptance; ends at the negedge after the tx_done edge.
  // If inj >= 0, a tx_start with inj_data is pulsed at that cycle while busy.
  task automatic check_frame(input logic [10:0] exp, input string name,
                             input int inj, input logic [7:0] inj_data);
    for (int c = 0; c < FB * DIV; c++) begin
      if (c == inj) begin
        tx_data  = inj_data;
        tx_start = 1'b1;
      end else if (c == inj + 1) begin
        tx_start = 1'b0;
      end
      chk({name, "_txd"}, 32'(txd), 32'(exp[c / DIV]));
      chk({name, "_busy"}, 32'(tx_busy), 32'd1);
      chk({name, "_done_low"}, 32'(tx_done), 32'd0);
      @(negedge clk);
    end
    chk({name, "_done_pulse"}, 32'(tx_done), 32'd1);
    chk({name, "_busy_end"}, 32'(tx_busy), 32'd0);
    chk({name, "_stop_txd"}, 32'(txd), 32'd1);
  endtask

  task automatic check_idle(input int n, input string name);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk({name, "_idle_txd"}, 32'(txd), 32'd1);
      chk({name, "_idle_busy"}, 32'(tx_busy), 32'd0);
      chk({name, "_idle_done"}, 32'(tx_done), 32'd0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h0F, 10'b1000011110, 1'b0};
    vecs[2] = '{8'h55, 10'b1010101010, 1'b0};
    vecs[3] = '{8'hAA, 10'b1101010100, 1'b0};
    vecs[4] = '{8'h81, 10'b1100000010, 1'b0};
    vecs[5] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[6] = '{8'h03, 10'b1000000110, 1'b0};
    vecs[7] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[8] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[9] = '{8'h01, 10'b1000000010, 1'b1};

    // reset held with tx_start asserted
    nrst     = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_txd", 32'(txd), 32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_done", 32'(tx_done), 32'd0);
    end
    tx_start = 1'b0;
    nrst     = 1'b1;
    check_idle(3, "post_rst");

    // single frames from the table
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].data);
      check_frame(frame_of(vecs[i]), $sformatf("vec%0d", i), -1, 8'h00);
      check_idle(4, $sformatf("vec%0d", i));
    end

    // tx_start while busy is ignored; no second frame
    launch(8'h0F);
    check_frame(frame_of(vecs[1]), "busy_rej", 35, 8'h3C);
    check_idle(3 * DIV, "busy_rej");

    // back-to-back: second tx_start in the tx_done cycle
    launch(8'h55);
    check_frame(frame_of(vecs[2]), "b2b_first", -1, 8'h00);
    launch(8'hAA);
    check_frame(frame_of(vecs[3]), "b2b_second", -1, 8'h00);
    check_idle(3, "b2b");

    // reset mid-frame aborts immediately
    launch(8'hA5);
    for (int c = 0; c < 47; c++) @(negedge clk);
    chk("mid_busy_before", 32'(tx_busy), 32'd1);
    nrst = 1'b0;
    @(negedge clk);
    chk("mid_rst_txd", 32'(txd), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_done", 32'(tx_done), 32'd0);
    nrst = 1'b1;
    check_idle(2 * DIV, "after_mid_rst");
    launch(8'h81);
    check_frame(frame_of(vecs[4]), "after_rst_81", -1, 8'h00);
    check_idle(3, "end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
